instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the single-issue MIPS core: holds the PC, issues word reads to the instruction cache and presents fetched instructions to the decode stage.
- Decode feeds `if_opcode` directly into the main control decoder.
- Stalls on the I-cache wait signal and on back-pressure from decode, absorbing one returned word in a skid register.
- Redirects on taken branch or jump, discarding any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, bubble word driven on `if_instr` when invalid.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- icache_read  output  1  fetch request
- icache_addr  output  30  word address, equal to pc[31:2]
- icache_rdata  input  32  returned instruction word
- icache_stall  input  1  cache busy; the request is complete in any cycle with icache_read=1 and icache_stall=0
- stall_in  input  1  decode cannot accept this cycle
- redirect_valid  input  1  taken branch or jump
- redirect_pc  input  32  target; bits [1:0] ignored and forced to 00
- if_valid  output  1  if_* outputs hold a valid instruction
- if_instr  output  32  instruction, or NOP_WORD when if_valid=0
- if_opcode  output  6  if_instr[31:26]
- if_pc  output  32  address of if_instr
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`.
- Reset values:
  - pc = RESET_PC, state = S_IDLE, if_valid = 0, if_instr = NOP_WORD.
  - if_pc = 0, icache_read = 0, skid empty, saved redirect = 0.
  - rst asserted mid-request abandons the request; the cache is reset on the same rst.
- Consumption: decode consumes if_* in any cycle with if_valid=1 and stall_in=0. Without new data, if_valid falls the next cycle.
- States:
  - S_IDLE: icache_read=0. Next state is S_REQ.
  - S_REQ: icache_read=1, icache_addr=pc[31:2]. Address is held stable while icache_stall=1. On completion:
    - redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0; data dropped; stay in S_REQ.
    - else if if_valid=1 and stall_in=1: skid <= {rdata, pc}; pc <= pc+4; go to S_FULL.
    - else: if_instr <= rdata; if_pc <= pc; if_valid <= 1; pc <= pc+4; stay in S_REQ. Back-to-back fetches give 1 instruction per cycle with a zero-wait cache.
  - S_REQ with icache_stall=1:
    - redirect_valid=1: save the target, if_valid <= 0, go to S_DRAIN.
    - otherwise the normal consumption rule applies.
  - S_DRAIN: icache_read=1 with the old address held (the request cannot be aborted).
    - A later redirect overwrites the saved target.
    - On completion: data discarded; pc <= saved target; go to S_REQ.
  - S_FULL: icache_read=0.
    - redirect_valid=1: skid cleared; pc <= target; if_valid <= 0; go to S_REQ.
    - else if stall_in=0: if_* <= skid contents; if_valid <= 1; go to S_REQ.
- Priority: redirect_valid beats stall_in and any returning data (it is a flush).
- Latency: with icache_stall tied to 0, the first if_valid=1 occurs in the 2nd cycle after rst deasserts (S_IDLE, then S_REQ), carrying the RESET_PC instruction.
- Arithmetic: pc+4 wraps from 32'hFFFF_FFFC to 0. if_pc_plus4 is computed the same way.

Decomposition:
- Shared package holds:
  - state encoding (S_IDLE, S_REQ, S_DRAIN, S_FULL);
  - NOP_WORD;
  - opcode field slice constants [31:26], shared with the main control decoder;
  - J-format target helper ({pc_plus4[31:28], target, 2'b00}), used by the redirect source.
- One sub-module: ifu_skid_reg, a 1-entry instruction+PC holding register with load/clear/valid.

Test Plan:
- Reset, zero-wait cache, rdata = 32'h8C01_0004 at addr 0 → if_valid=1 two cycles later, if_pc=0, if_opcode=6'b100011, then if_pc=4, 8 on consecutive cycles.
- icache_stall held high 3 cycles → icache_addr constant and icache_read=1 throughout; if_valid=0 until data returns.
- stall_in=1 while if_valid=1 and a fetch completes → if_* unchanged, S_FULL, icache_read=0. Release stall_in → skid word appears next cycle; then sequential PCs with no instruction skipped or duplicated.
- redirect_valid with redirect_pc=32'h0000_0043 while idle-streaming → next icache_addr=30'h10 (0x40 >> 2), if_valid=0 for one cycle, then first output has if_pc=0x40.
- Redirect during icache_stall=1, then a second redirect to 0x80 while draining → old word discarded, never output; next fetch address is 0x80.
- pc=32'hFFFF_FFFC → if_pc_plus4=0 and next fetch address is 0; also rst pulse mid-stall → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours in the core.
// Covers the fetch FSM encoding, the bubble word, the opcode slice and the J-format target.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_FULL  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Opcode field position, shared with the main control decoder.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // J-format jump target: upper nibble of pc+4, 26-bit index, word aligned.
    function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                             input logic [25:0] target);
        return {pc_plus4[31:28], target, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_skid_reg.sv
// One-entry holding register for an instruction word and its PC.
// Catches a fetch that completes while decode is stalled.
module ifu_skid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to the I-cache and hands
// instructions to decode, with a one-word skid for decode back-pressure.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = instr_fetch_unit_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [29:0] icache_addr,
    input  logic [31:0] icache_rdata,
    input  logic        icache_stall,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    import instr_fetch_unit_pkg::*;

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic [31:0] saved_pc_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;

    logic        req_done;
    logic        consumed;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;
    logic        skid_load;
    logic        skid_clear;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    assign icache_read  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign icache_addr  = pc_q[31:2];
    assign req_done     = icache_read && !icache_stall;
    assign consumed     = if_valid_q && !stall_in;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4     = pc_q + 32'd4;

    // Skid fills only when a fetch lands on top of an instruction decode is holding.
    assign skid_load  = (state_q == S_REQ) && req_done && !redirect_valid &&
                        if_valid_q && stall_in;
    assign skid_clear = (state_q == S_FULL) && (redirect_valid || !stall_in);

    ifu_skid_reg u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (icache_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            saved_pc_q <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_WORD;
            if_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    if (redirect_valid) pc_q <= redirect_tgt;
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        if_valid_q <= 1'b0;
                        if (req_done) begin
                            pc_q <= redirect_tgt;
                        end else begin
                            // The outstanding read cannot be aborted; park the target.
                            saved_pc_q <= redirect_tgt;
                            state_q    <= S_DRAIN;
                        end
                    end else if (skid_load) begin
                        pc_q    <= pc_plus4;
                        state_q <= S_FULL;
                    end else if (req_done) begin
                        if_instr_q <= icache_rdata;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_plus4;
                    end else if (consumed) begin
                        if_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if_valid_q <= 1'b0;
                    if (req_done) begin
                        pc_q    <= redirect_valid ? redirect_tgt : saved_pc_q;
                        state_q <= S_REQ;
                    end else if (redirect_valid) begin
                        saved_pc_q <= redirect_tgt;
                    end
                end
                S_FULL: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_tgt;
                        if_valid_q <= 1'b0;
                        state_q    <= S_REQ;
                    end else if (!stall_in && skid_valid) begin
                        if_instr_q <= skid_instr;
                        if_pc_q    <= skid_pc;
                        if_valid_q <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_valid_q ? if_instr_q : NOP_WORD;
    assign if_opcode   = if_instr[OPC_MSB:OPC_LSB];
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for the fetch stage; the I-cache returns 0x8C01_0004 + word address.
module tb_instr_fetch_unit;

    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_read;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign icache_rdata = 32'h8C01_0004 + {2'b00, icache_addr};

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_stall   (icache_stall),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    // Advance one cycle and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        check_eq({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        check_eq({tag, ".pc"},    if_pc,    pc);
        check_eq({tag, ".instr"}, if_instr, instr);
    endtask

    initial begin
        rst            = 1'b1;
        icache_stall   = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();

        // Reset state
        check_out("reset", 1'b0, 32'h0, 32'h0);
        check_eq("reset.read",  {31'd0, icache_read}, 32'd0);
        check_eq("reset.plus4", if_pc_plus4, 32'h4);
        rst = 1'b0;

        // Zero-wait streaming from RESET_PC
        step();
        check_eq("idle2req.read", {31'd0, icache_read}, 32'd1);
        check_eq("idle2req.addr", {2'b00, icache_addr}, 32'h0);
        check_eq("idle2req.valid", {31'd0, if_valid}, 32'd0);
        step();
        check_out("fetch0", 1'b1, 32'h0, 32'h8C01_0004);
        check_eq("fetch0.opcode", {26'd0, if_opcode}, 32'h23);
        step();
        check_out("fetch4", 1'b1, 32'h4, 32'h8C01_0005);
        step();
        check_out("fetch8", 1'b1, 32'h8, 32'h8C01_0006);

        // Cache stall for three cycles at pc 0xC
        icache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("cstall%0d.addr", i), {2'b00, icache_addr}, 32'h3);
            check_eq($sformatf("cstall%0d.read", i), {31'd0, icache_read}, 32'd1);
            check_eq($sformatf("cstall%0d.valid", i), {31'd0, if_valid}, 32'd0);
        end
        icache_stall = 1'b0;
        step();
        check_out("after_cstall", 1'b1, 32'hC, 32'h8C01_0007);

        // Decode back-pressure: next word goes to the skid
        stall_in = 1'b1;
        step();
        check_out("skid_fill", 1'b1, 32'hC, 32'h8C01_0007);
        check_eq("skid_fill.read", {31'd0, icache_read}, 32'd0);
        step();
        check_out("skid_hold", 1'b1, 32'hC, 32'h8C01_0007);
        check_eq("skid_hold.read", {31'd0, icache_read}, 32'd0);
        stall_in = 1'b0;
        step();
        check_out("skid_drain", 1'b1, 32'h10, 32'h8C01_0008);
        check_eq("skid_drain.addr", {2'b00, icache_addr}, 32'h5);
        step();
        check_out("post_skid", 1'b1, 32'h14, 32'h8C01_0009);

        // Redirect while streaming, unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        check_eq("redir.addr", {2'b00, icache_addr}, 32'h10);
        check_eq("redir.valid", {31'd0, if_valid}, 32'd0);
        step();
        check_out("redir_tgt", 1'b1, 32'h40, 32'h8C01_0014);

        // Redirect under cache stall, then a second redirect while draining
        icache_stall   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        check_eq("drain0.addr", {2'b00, icache_addr}, 32'h11);
        check_eq("drain0.read", {31'd0, icache_read}, 32'd1);
        check_eq("drain0.valid", {31'd0, if_valid}, 32'd0);
        redirect_pc = j_target(32'h0000_1000, 26'h20);
        step();
        redirect_valid = 1'b0;
        check_eq("drain1.addr", {2'b00, icache_addr}, 32'h11);
        icache_stall = 1'b0;
        step();
        check_eq("drain_done.valid", {31'd0, if_valid}, 32'd0);
        check_eq("drain_done.addr", {2'b00, icache_addr}, 32'h20);
        step();
        check_out("redir80", 1'b1, 32'h80, 32'h8C01_0024);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check_eq("wrap.addr", {2'b00, icache_addr}, 32'h3FFF_FFFF);
        step();
        check_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'hCC01_0003);
        check_eq("wrap_top.plus4", if_pc_plus4, 32'h0);
        check_eq("wrap_top.next_addr", {2'b00, icache_addr}, 32'h0);
        step();
        check_out("wrap_zero", 1'b1, 32'h0, 32'h8C01_0004);

        // Reset pulse in the middle of a stalled request
        icache_stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_out("rst_mid", 1'b0, 32'h0, 32'h0);
        check_eq("rst_mid.read",  {31'd0, icache_read}, 32'd0);
        check_eq("rst_mid.plus4", if_pc_plus4, 32'h4);
        rst          = 1'b0;
        icache_stall = 1'b0;
        step();
        check_eq("rst_restart.addr", {2'b00, icache_addr}, 32'h0);
        check_eq("rst_restart.read", {31'd0, icache_read}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
